// File: rtl/vsync_timing_if.sv
// Vertical timing bus: horizontal-stage inputs in, vertical timing and pixel coordinates out.
interface vsync_timing_if;
    localparam int unsigned CNT_W   = 10;
    localparam int unsigned STATE_W = 2;
    localparam int unsigned FRAME_W = 8;

    logic               hsync_pulse;
    logic [CNT_W-1:0]   x;
    logic               vsync;
    logic [CNT_W-1:0]   y;
    logic               vsync_pulse;
    logic [STATE_W-1:0] v_state;
    logic               video_on;
    logic [CNT_W-1:0]   pixel_x;
    logic [CNT_W-1:0]   pixel_y;
    logic [FRAME_W-1:0] frame_count;

    // Horizontal stage / consumer side
    modport master (
        output hsync_pulse, x,
        input  vsync, y, vsync_pulse, v_state, video_on, pixel_x, pixel_y, frame_count
    );

    // Vertical timing stage side
    modport slave (
        input  hsync_pulse, x,
        output vsync, y, vsync_pulse, v_state, video_on, pixel_x, pixel_y, frame_count
    );
endinterface

// File: rtl/vsync_timing.sv
// Vertical timing stage for 640x480@60: line counter, vsync, region FSM,
// frame counter and registered active-area pixel coordinates.
module vsync_timing #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10
) (
    input  logic           clk_25mhz,
    input  logic           rst,
    vsync_timing_if.slave  bus
);
    localparam int unsigned CNT_W       = 10;
    localparam int unsigned FRAME_W     = 8;
    localparam int unsigned V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned V_ACT_START = V_SYNC + V_BP;
    localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE;
    localparam int unsigned H_ACT_START = H_SYNC + H_BP;
    localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_BACK   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_FRONT  = 2'd3
    } v_state_t;

    v_state_t          state_q;
    v_state_t          state_d;
    logic [CNT_W-1:0]  y_d;
    logic              wrap_c;
    logic              vis_c;

    // Next line count; wrap_c marks the last-line -> line 0 edge
    always_comb begin
        y_d    = bus.y;
        wrap_c = 1'b0;
        if (bus.hsync_pulse) begin
            if (bus.y == CNT_W'(V_TOTAL - 1)) begin
                y_d    = '0;
                wrap_c = 1'b1;
            end else begin
                y_d = bus.y + CNT_W'(1);
            end
        end
    end

    // Region FSM next state, advanced only on line boundaries
    always_comb begin
        state_d = state_q;
        if (bus.hsync_pulse) begin
            unique case (state_q)
                ST_SYNC:   if (y_d == CNT_W'(V_SYNC))      state_d = ST_BACK;
                ST_BACK:   if (y_d == CNT_W'(V_ACT_START)) state_d = ST_ACTIVE;
                ST_ACTIVE: if (y_d == CNT_W'(V_ACT_END))   state_d = ST_FRONT;
                ST_FRONT:  if (wrap_c)                     state_d = ST_SYNC;
                default:                                   state_d = ST_SYNC;
            endcase
        end
    end

    // Visible-pixel decode from the incoming x and the current line region
    always_comb begin
        vis_c = (bus.x >= CNT_W'(H_ACT_START)) && (bus.x < CNT_W'(H_ACT_END)) &&
                (state_q == ST_ACTIVE);
    end

    // Region state register
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.v_state = state_q;

    // Line count, sync, frame strobe/counter and active-area outputs
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            bus.y           <= '0;
            bus.vsync       <= 1'b0;
            bus.vsync_pulse <= 1'b0;
            bus.frame_count <= '0;
            bus.video_on    <= 1'b0;
            bus.pixel_x     <= '0;
            bus.pixel_y     <= '0;
        end else begin
            bus.y           <= y_d;
            bus.vsync       <= (y_d >= CNT_W'(V_SYNC));
            bus.vsync_pulse <= wrap_c;
            if (wrap_c) begin
                bus.frame_count <= bus.frame_count + FRAME_W'(1);
            end
            bus.video_on    <= vis_c;
            bus.pixel_x     <= vis_c ? (bus.x - CNT_W'(H_ACT_START)) : '0;
            bus.pixel_y     <= vis_c ? (bus.y - CNT_W'(V_ACT_START)) : '0;
        end
    end
endmodule

// File: tb/tb_vsync_timing.sv
// Testbench for vsync_timing: directed line/frame sequences with random x,
// every cycle compared against a pulse-counting reference model.
module tb_vsync_timing;
    localparam int unsigned V_TOTAL = 525;

    logic clk_25mhz;
    logic rst;

    vsync_timing_if bus ();

    vsync_timing dut (
        .clk_25mhz (clk_25mhz),
        .rst       (rst),
        .bus       (bus)
    );

    initial clk_25mhz = 1'b0;
    always #20 clk_25mhz = ~clk_25mhz;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: everything derives from the number of line pulses since reset
    int unsigned n_pulses = 0;
    logic        e_pulse  = 1'b0;
    logic        e_vo     = 1'b0;
    int unsigned e_px     = 0;
    int unsigned e_py     = 0;

    function automatic int unsigned region(input int unsigned yy);
        if (yy < 2)   return 0;
        if (yy < 35)  return 1;
        if (yy < 515) return 2;
        return 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (pulses=%0d)", tag, obs, exp, n_pulses);
        end
    endtask

    // One clock: apply inputs, update model on the edge, compare all outputs after it
    task automatic step(input logic r, input logic h, input logic [9:0] xv);
        int unsigned py;
        int unsigned ey;
        bit          vis;
        rst             = r;
        bus.hsync_pulse = h;
        bus.x           = xv;
        py = n_pulses % V_TOTAL;
        @(posedge clk_25mhz);
        if (r) begin
            n_pulses = 0;
            e_pulse  = 1'b0;
            e_vo     = 1'b0;
            e_px     = 0;
            e_py     = 0;
        end else begin
            vis  = (xv >= 144) && (xv < 784) && (py >= 35) && (py < 515);
            e_vo = vis;
            e_px = vis ? (int'(xv) - 144) : 0;
            e_py = vis ? (py - 35) : 0;
            if (h) n_pulses++;
            e_pulse = h && ((n_pulses % V_TOTAL) == 0);
        end
        #1;
        ey = n_pulses % V_TOTAL;
        chk("y",           32'(bus.y),           ey);
        chk("vsync",       32'(bus.vsync),       (ey >= 2) ? 1 : 0);
        chk("v_state",     32'(bus.v_state),     region(ey));
        chk("vsync_pulse", 32'(bus.vsync_pulse), 32'(e_pulse));
        chk("frame_count", 32'(bus.frame_count), (n_pulses / V_TOTAL) % 256);
        chk("video_on",    32'(bus.video_on),    32'(e_vo));
        chk("pixel_x",     32'(bus.pixel_x),     e_px);
        chk("pixel_y",     32'(bus.pixel_y),     e_py);
    endtask

    // Full 800-pixel line as the horizontal stage produces it
    task automatic full_line();
        int unsigned vo_cnt;
        int unsigned ly;
        vo_cnt = 0;
        step(1'b0, 1'b1, 10'd0);
        ly = n_pulses % V_TOTAL;
        for (int xi = 1; xi < 800; xi++) begin
            step(1'b0, 1'b0, 10'(xi));
            if (bus.video_on === 1'b1) vo_cnt++;
        end
        chk("line_video_on_cycles", vo_cnt, (ly >= 35 && ly < 515) ? 640 : 0);
    endtask

    // Compressed line hitting the horizontal active-area corners plus random x
    task automatic short_line();
        step(1'b0, 1'b1, 10'd0);
        step(1'b0, 1'b0, 10'd143);
        step(1'b0, 1'b0, 10'd144);
        step(1'b0, 1'b0, 10'd145);
        step(1'b0, 1'b0, 10'($urandom_range(0, 1023)));
        step(1'b0, 1'b0, 10'd783);
        step(1'b0, 1'b0, 10'd784);
        step(1'b0, 1'b0, 10'($urandom_range(144, 783)));
    endtask

    task automatic run_frame(input bit first);
        int unsigned ny;
        for (int i = 0; i < int'(V_TOTAL); i++) begin
            ny = (n_pulses + 1) % V_TOTAL;
            if ((first && ny <= 3) || ny == 35 || ny == 514) full_line();
            else short_line();
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.hsync_pulse = 1'b0;
        bus.x           = '0;

        // Reset held with random pulses and x
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 799)));
        end
        step(1'b0, 1'b0, 10'($urandom_range(0, 799)));
        step(1'b0, 1'b0, 10'($urandom_range(0, 799)));
        chk("idle_y_after_reset", 32'(bus.y), 0);

        // Three frames: sync edges, region changes, active corners, wraps
        run_frame(1'b1);
        chk("frame_count_after_1", 32'(bus.frame_count), 1);
        run_frame(1'b0);
        run_frame(1'b0);
        step(1'b0, 1'b0, 10'd0);
        chk("pulse_one_cycle_only", 32'(bus.vsync_pulse), 0);

        // Fast frames: a line pulse every cycle with random x
        for (int i = 0; i < 20 * int'(V_TOTAL); i++) begin
            step(1'b0, 1'b1, 10'($urandom_range(0, 1023)));
        end
        chk("frame_count_after_23", 32'(bus.frame_count), 23);

        // Realign to line 0 of a fresh frame, then run to line 300 and reset mid-line
        while ((n_pulses % V_TOTAL) != 0) short_line();
        for (int i = 0; i < 300; i++) short_line();
        step(1'b0, 1'b0, 10'd400);
        chk("midframe_video_on_before_reset", 32'(bus.video_on), 1);
        step(1'b1, 1'b1, 10'd401);
        chk("midframe_reset_y", 32'(bus.y), 0);
        chk("midframe_reset_frame_count", 32'(bus.frame_count), 0);
        for (int i = 0; i < 40; i++) short_line();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vsync_timing.md
Name: vsync_timing

Overview:
- Vertical timing stage for the 640x480@60 VGA path.
- Sits directly downstream of the horizontal sync generator. Consumes its end-of-line pulse and x count.
- Produces the vertical sync, line count, frame-start pulse, display-enable and active-area pixel coordinates for the pixel/colour stage.
- Tracks the vertical region with an explicit 4-state FSM and keeps an 8-bit frame counter.

Parameters:
H_SYNC, 96, horizontal sync width in pixel clocks (x 0..95)
H_BP, 48, horizontal back porch in pixel clocks
H_ACTIVE, 640, visible pixels per line
V_SYNC, 2, vertical sync width in lines
V_BP, 33, vertical back porch in lines
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch in lines; V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP = 525

Ports:
clk_25mhz  input  1  pixel clock, the only clock
rst  input  1  synchronous, active-high reset
hsync_pulse  input  1  one-cycle end-of-line strobe from the horizontal stage, high during the cycle x==0
x  input  10  horizontal count 0..799 from the horizontal stage
vsync  output  1  vertical sync, low for lines 0..V_SYNC-1, high otherwise
y  output  10  line count 0..V_TOTAL-1
vsync_pulse  output  1  one-cycle strobe on the edge where y wraps to 0
v_state  output  2  0=SYNC, 1=BACK, 2=ACTIVE, 3=FRONT
video_on  output  1  high when the registered pixel is inside the visible area
pixel_x  output  10  x-(H_SYNC+H_BP) when video_on, else 0
pixel_y  output  10  y-(V_SYNC+V_BP) when video_on, else 0
frame_count  output  8  completed-frame counter, wraps 255->0

Behaviour:
- Reset (rst high at posedge):
  - Outputs: y=0, vsync=0, vsync_pulse=0, v_state=SYNC, video_on=0, pixel_x=0, pixel_y=0, frame_count=0.
  - rst has priority over a coincident hsync_pulse.
  - The upstream stage has no reset, so after a mid-frame reset the frame is misaligned until the next natural wrap. This is accepted.
- Line counting:
  - On a posedge with hsync_pulse=1: y <= (y==V_TOTAL-1) ? 0 : y+1.
  - y therefore changes one cycle after the x==0 cycle.
  - Without hsync_pulse, y holds.
- vsync:
  - Registered and computed from the next y value, so it changes on the same edge as y.
  - Low while y<V_SYNC, high otherwise.
- vsync_pulse:
  - 1 for exactly one cycle, on the edge where y goes V_TOTAL-1 -> 0. 0 at all other times.
  - frame_count increments on that same edge, modulo 256.
- FSM: transitions only on hsync_pulse edges, same edge as y.
  - SYNC -> BACK when next y == V_SYNC (2).
  - BACK -> ACTIVE when next y == V_SYNC+V_BP (35).
  - ACTIVE -> FRONT when next y == 515.
  - FRONT -> SYNC when next y wraps to 0.
  - v_state must always equal the region decode of y. A mismatch is a bug and is checked by assertion.
- Active area:
  - Registered with 1-cycle latency from the x input and current y.
  - video_on <= (H_SYNC+H_BP <= x < H_SYNC+H_BP+H_ACTIVE) && (v_state==ACTIVE), i.e. 144<=x<784 and 35<=y<515.
  - pixel_x/pixel_y are registered on the same edge as video_on. They hold the offsets when video_on is 1 and are forced to 0 otherwise.
  - Subtraction is done in 10 bits; no negative value is ever output.
- Widths:
  - All counts are 10-bit unsigned.
  - x values >=800 are treated as not visible; no error flag.
- Simultaneous events: hsync_pulse in the last line updates y, vsync, v_state, vsync_pulse and frame_count on one edge, consistently.

Test Plan:
- Reset: hold rst 3 cycles with random hsync_pulse -> y=0, vsync=0, v_state=0, video_on=0, frame_count=0 throughout; first pulse after release -> y=1.
- Vertical sync edges: drive 800-cycle lines from a model of the horizontal stage -> vsync 0 for y=0,1; rises on the edge y becomes 2; v_state 0->1 at y=2, 1->2 at y=35, 2->3 at y=515.
- Active corners:
  - y=35, x=144 -> next cycle video_on=1, pixel_x=0, pixel_y=0.
  - y=514, x=783 -> next cycle pixel_x=639, pixel_y=479.
  - x=143 or x=784 -> video_on=0, pixel_x=pixel_y=0.
- Frame wrap: from y=524 apply hsync_pulse -> y=0, vsync=0, v_state=0, vsync_pulse=1 for exactly one cycle, frame_count +1. Run 256 frames -> frame_count returns to 0; exactly 640*480 video_on cycles counted per frame.
- Reset mid-frame: at y=300 (video_on active), assert rst coincident with hsync_pulse -> next cycle y=0, vsync=0, video_on=0, no vsync_pulse, frame_count=0.
